// File: rtl/npc_pkg.sv
// ---------------------------------------------------------------------------
// npc_pkg -- shared definitions for the NPC fetch path.
//
// Contents:
//   NPC_RESET_PC    : first PC the fetch stage issues after reset
//   IMEM_BASE_ADDR  : default byte address of instruction memory word 0
//   imem_state_e    : instruction-memory request FSM states (2-bit encoding)
//   imem_in_range() : no-wrap range check of a byte address against a window
// ---------------------------------------------------------------------------
package npc_pkg;

    // Fetch stage starts at the base of instruction memory.
    localparam logic [31:0] NPC_RESET_PC   = 32'h8000_0000;
    localparam logic [31:0] IMEM_BASE_ADDR = NPC_RESET_PC;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_WAIT = 2'd1,
        IMEM_RESP = 2'd2
    } imem_state_e;

    // True when base <= addr < base + 4*2^depth_log2.
    // The subtraction is done in 33 bits so an address below base shows up
    // as a borrow in bit 32 instead of wrapping to a large positive offset.
    function automatic logic imem_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned depth_log2);
        logic [32:0] off;
        logic [32:0] span;
        off  = {1'b0, addr} - {1'b0, base};
        span = 33'd4 << depth_log2;
        return !off[32] && (off < span);
    endfunction

endpackage

// File: rtl/imem_sram_if.sv
// ---------------------------------------------------------------------------
// imem_sram_if -- fetch and preload bus of the instruction SRAM.
//
// Handshake: ren is a request strobe that the memory samples only while
// busy=0; a request seen while busy=1 is dropped (no queueing). The
// response is the single-cycle strobe rvalid with rdata/rerr; there is no
// backpressure, so the requester must take the response in that cycle.
// rdata/rerr keep their value between responses.
//
// Signals:
//   ren, raddr[31:0]          fetch request and byte address   (master -> slave)
//   we, waddr[31:0], wdata    preload write port               (master -> slave)
//   rdata[31:0], rvalid, rerr response word, strobe, fault     (slave -> master)
//   busy                      request slot occupied            (slave -> master)
// ---------------------------------------------------------------------------
interface imem_sram_if;
    logic        ren;
    logic [31:0] raddr;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rerr;
    logic        busy;

    modport master (
        output ren, raddr, we, waddr, wdata,
        input  rdata, rvalid, rerr, busy
    );

    modport slave (
        input  ren, raddr, we, waddr, wdata,
        output rdata, rvalid, rerr, busy
    );
endinterface

// File: rtl/imem_array.sv
// ---------------------------------------------------------------------------
// imem_array -- 2^DEPTH_LOG2 x 32-bit storage, one write port, one
// registered read port.
//
// Ports:
//   clk        clock
//   rst        synchronous reset of the read register only (not the array)
//   we, widx, wdata   write port
//   re, ridx   read enable and word index; rdata updates on the edge
//   rclr       load zero into the read register (takes priority over re)
//   rdata      registered read data
//
// A read and a write to the same word on the same edge return the old word.
// ---------------------------------------------------------------------------
module imem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] widx,
    input  logic [31:0]           wdata,
    input  logic                  re,
    input  logic                  rclr,
    input  logic [DEPTH_LOG2-1:0] ridx,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    // No reset on the storage: contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rclr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[ridx];
        end
    end

endmodule

// File: rtl/imem_sram.sv
// ---------------------------------------------------------------------------
// imem_sram -- instruction SRAM model with fixed, programmable fetch latency.
//
// Parameters:
//   DEPTH_LOG2 : 2^DEPTH_LOG2 32-bit words
//   LATENCY    : cycles from request sample to rvalid, legal 1..15
//   BASE_ADDR  : byte address of word 0
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        synchronous, active-high reset (array contents are kept)
//   bus        imem_sram_if.slave: fetch request/response and preload write
//   state_dbg  current request FSM state
//
// One request at a time: IDLE samples ren, WAIT counts down, RESP presents
// the response for one cycle. Faulting requests (misaligned or outside the
// window) take the same latency and return rerr=1, rdata=0.
// ---------------------------------------------------------------------------
module imem_sram
    import npc_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = IMEM_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    imem_sram_if.slave  bus,
    output imem_state_e state_dbg
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    imem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        rerr_q;

    logic                  capture;
    logic [31:0]           cap_addr;
    logic                  cap_ok;
    logic [DEPTH_LOG2-1:0] cap_idx;
    logic                  wr_ok;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [31:0]           arr_rdata;

    // ---------------- request FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IMEM_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        case (state_q)
            IMEM_IDLE: begin
                if (bus.ren) begin
                    addr_d  = bus.raddr;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? IMEM_RESP : IMEM_WAIT;
                end
            end
            IMEM_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IMEM_RESP;
                end
            end
            IMEM_RESP: begin
                state_d = IMEM_IDLE;
            end
            default: begin
                state_d = IMEM_IDLE;
            end
        endcase
    end

    // ---------------- response capture ----------------
    // The response is registered on the edge that enters RESP. With
    // LATENCY=1 that edge is the sampling edge itself, so the address comes
    // straight from the bus instead of the (not yet loaded) latch.
    assign capture  = !rst && (state_d == IMEM_RESP) && (state_q != IMEM_RESP);
    assign cap_addr = (state_q == IMEM_IDLE) ? bus.raddr : addr_q;
    assign cap_ok   = (cap_addr[1:0] == 2'b00)
                   && imem_in_range(cap_addr, BASE_ADDR, DEPTH_LOG2);
    assign cap_idx  = DEPTH_LOG2'((cap_addr - BASE_ADDR) >> 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            rerr_q <= 1'b0;
        end else if (capture) begin
            rerr_q <= !cap_ok;
        end
    end

    // ---------------- preload write ----------------
    assign wr_ok  = bus.we && !rst && (bus.waddr[1:0] == 2'b00)
                 && imem_in_range(bus.waddr, BASE_ADDR, DEPTH_LOG2);
    assign wr_idx = DEPTH_LOG2'((bus.waddr - BASE_ADDR) >> 2);

    imem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .widx  (wr_idx),
        .wdata (bus.wdata),
        .re    (capture && cap_ok),
        .rclr  (capture && !cap_ok),
        .ridx  (cap_idx),
        .rdata (arr_rdata)
    );

    // ---------------- outputs ----------------
    assign bus.rdata  = arr_rdata;
    assign bus.rerr   = rerr_q;
    assign bus.rvalid = (state_q == IMEM_RESP);
    assign bus.busy   = (state_q != IMEM_IDLE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_imem_sram.sv
// ---------------------------------------------------------------------------
// tb_imem_sram -- scoreboard bench for imem_sram.
// dut2: default build (LATENCY=2); dut1: LATENCY=1 build. Both share clk/rst.
// Expected responses are {cycle, rerr, rdata}, pushed by the drivers and
// popped by one monitor per DUT whenever rvalid is seen.
// ---------------------------------------------------------------------------
module tb_imem_sram;
    import npc_pkg::*;

    localparam int W = 65;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    logic [W-1:0] exp2_q[$];
    logic [W-1:0] exp1_q[$];

    imem_state_e st2, st1;

    imem_sram_if bus2();
    imem_sram_if bus1();

    imem_sram #(.DEPTH_LOG2(10), .LATENCY(2), .BASE_ADDR(32'h8000_0000)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus2),
        .state_dbg (st2)
    );

    imem_sram #(.DEPTH_LOG2(10), .LATENCY(1), .BASE_ADDR(32'h8000_0000)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus1),
        .state_dbg (st1)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, pending2=%0d pending1=%0d",
                 exp2_q.size(), exp1_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wr(input int sel, input logic [31:0] a, input logic [31:0] d);
        if (sel == 2) begin
            bus2.we = 1'b1; bus2.waddr = a; bus2.wdata = d;
        end else begin
            bus1.we = 1'b1; bus1.waddr = a; bus1.wdata = d;
        end
        tick();
        bus2.we = 1'b0;
        bus1.we = 1'b0;
    endtask

    // One-cycle request; waits until the DUT is idle again before returning.
    task automatic req(input int sel, input logic [31:0] a,
                       input logic [31:0] d, input logic e);
        int lat;
        lat = (sel == 1) ? 1 : 2;
        if (sel == 2) begin
            exp2_q.push_back({32'(cyc + lat), e, d});
            bus2.ren = 1'b1; bus2.raddr = a;
        end else begin
            exp1_q.push_back({32'(cyc + lat), e, d});
            bus1.ren = 1'b1; bus1.raddr = a;
        end
        tick();
        bus2.ren = 1'b0;
        bus1.ren = 1'b0;
        repeat (lat) tick();
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (bus2.rvalid) begin
            if (exp2_q.size() == 0) begin
                n_total++;
                $display("FAIL lat2_unexpected_rvalid: got rdata %0h, expected no response (cycle %0d)",
                         bus2.rdata, cyc);
            end else begin
                e = exp2_q.pop_front();
                check("lat2_cycle", 64'(cyc), 64'(e[64:33]));
                check("lat2_rerr", 64'(bus2.rerr), 64'(e[32]));
                check("lat2_rdata", 64'(bus2.rdata), 64'(e[31:0]));
            end
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (bus1.rvalid) begin
            if (exp1_q.size() == 0) begin
                n_total++;
                $display("FAIL lat1_unexpected_rvalid: got rdata %0h, expected no response (cycle %0d)",
                         bus1.rdata, cyc);
            end else begin
                e = exp1_q.pop_front();
                check("lat1_cycle", 64'(cyc), 64'(e[64:33]));
                check("lat1_rerr", 64'(bus1.rerr), 64'(e[32]));
                check("lat1_rdata", 64'(bus1.rdata), 64'(e[31:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus2.ren = 1'b0; bus2.raddr = '0; bus2.we = 1'b0; bus2.waddr = '0; bus2.wdata = '0;
        bus1.ren = 1'b0; bus1.raddr = '0; bus1.we = 1'b0; bus1.waddr = '0; bus1.wdata = '0;
        rst = 1'b1;
        tick();
        tick();

        // reset state
        check("rst_state2", 64'(st2), 64'(IMEM_IDLE));
        check("rst_rvalid2", 64'(bus2.rvalid), 64'd0);
        check("rst_rerr2", 64'(bus2.rerr), 64'd0);
        check("rst_rdata2", 64'(bus2.rdata), 64'd0);
        check("rst_busy2", 64'(bus2.busy), 64'd0);
        check("rst_state1", 64'(st1), 64'(IMEM_IDLE));
        check("rst_busy1", 64'(bus1.busy), 64'd0);
        rst = 1'b0;

        // preload both memories
        wr(2, 32'h8000_0000, 32'h0000_0413);
        wr(2, 32'h8000_0004, 32'h0000_0513);
        wr(2, 32'h8000_0008, 32'h1234_5678);
        wr(2, 32'h8000_0010, 32'h0000_0010);
        wr(2, 32'h8000_0FFC, 32'hCAFE_F00D);
        wr(2, 32'h8000_1000, 32'hBAD0_BAD0);   // out of range, dropped
        wr(1, 32'h8000_0008, 32'h1234_5678);

        // reset again with ren/we asserted: both must be ignored
        rst = 1'b1;
        bus2.ren = 1'b1; bus2.raddr = 32'h8000_0000;
        bus2.we = 1'b1; bus2.waddr = 32'h8000_0010; bus2.wdata = 32'h1111_1111;
        tick();
        rst = 1'b0;
        bus2.ren = 1'b0;
        bus2.we = 1'b0;
        check("rst_ren_ignored", 64'(bus2.busy), 64'd0);

        // basic fetch, LATENCY=2, busy for two cycles
        exp2_q.push_back({32'(cyc + 2), 1'b0, 32'h0000_0413});
        bus2.ren = 1'b1; bus2.raddr = 32'h8000_0000;
        tick();
        bus2.ren = 1'b0;
        check("busy_wait", 64'(bus2.busy), 64'd1);
        tick();
        check("busy_resp", 64'(bus2.busy), 64'd1);
        tick();
        check("busy_idle", 64'(bus2.busy), 64'd0);

        // level-held ren for 9 cycles: responses every 3 cycles
        exp2_q.push_back({32'(cyc + 2), 1'b0, 32'h0000_0513});
        exp2_q.push_back({32'(cyc + 5), 1'b0, 32'h0000_0513});
        exp2_q.push_back({32'(cyc + 8), 1'b0, 32'h0000_0513});
        bus2.ren = 1'b1; bus2.raddr = 32'h8000_0004;
        repeat (9) tick();
        bus2.ren = 1'b0;
        tick();

        // faults and window boundaries
        req(2, 32'h8000_0002, 32'h0, 1'b1);
        req(2, 32'h8000_1000, 32'h0, 1'b1);
        req(2, 32'h7FFF_FFFC, 32'h0, 1'b1);
        check("rerr_hold", 64'(bus2.rerr), 64'd1);
        check("rdata_zero_hold", 64'(bus2.rdata), 64'd0);
        req(2, 32'hFFFF_FFFC, 32'h0, 1'b1);
        req(2, 32'h8000_0FFC, 32'hCAFE_F00D, 1'b0);
        check("rdata_hold", 64'(bus2.rdata), 64'hCAFE_F00D);
        check("rerr_clear_hold", 64'(bus2.rerr), 64'd0);
        req(2, 32'h8000_0010, 32'h0000_0010, 1'b0);   // write during rst ignored

        // reset the cycle after ren is sampled: request aborted
        bus2.ren = 1'b1; bus2.raddr = 32'h8000_0000;
        tick();
        bus2.ren = 1'b0;
        check("abort_busy_before", 64'(bus2.busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_rdata_cleared", 64'(bus2.rdata), 64'd0);
        for (int i = 0; i < 5; i++) begin
            check("abort_no_rvalid", 64'(bus2.rvalid), 64'd0);
            check("abort_busy", 64'(bus2.busy), 64'd0);
            tick();
        end
        req(2, 32'h8000_0008, 32'h1234_5678, 1'b0);
        req(2, 32'h8000_0000, 32'h0000_0413, 1'b0);

        // LATENCY=1: same-edge write on the capture edge returns old data
        exp1_q.push_back({32'(cyc + 1), 1'b0, 32'h1234_5678});
        bus1.ren = 1'b1; bus1.raddr = 32'h8000_0008;
        bus1.we = 1'b1; bus1.waddr = 32'h8000_0008; bus1.wdata = 32'hDEAD_BEEF;
        tick();
        bus1.ren = 1'b0;
        bus1.we = 1'b0;
        check("lat1_busy_resp", 64'(bus1.busy), 64'd1);
        tick();
        req(1, 32'h8000_0008, 32'hDEAD_BEEF, 1'b0);
        req(1, 32'h8000_0009, 32'h0, 1'b1);
        req(1, 32'h8000_0008, 32'hDEAD_BEEF, 1'b0);

        repeat (4) tick();
        check("lat2_queue_drained", 64'(exp2_q.size()), 64'd0);
        check("lat1_queue_drained", 64'(exp1_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
